// File: rtl/dz_pkg.sv
// Shared constants and types for the dot-matrix scan-bus decoder.
package dz_pkg;

   localparam int DZ_ROWS = 8;
   localparam int DZ_COLS = 8;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPT, S_HOLD} dz_scan_state_t;

   typedef logic [2:0] dz_row_idx_t;

   typedef enum logic [1:0] {IDLE, ACTIVE, MULTI} dz_bus_class_t;

endpackage

// File: rtl/dz_scan_decoder_dec.sv
// dz_row_onehot_dec: classifies the active-low row select and extracts the driven row index.
module dz_row_onehot_dec
   import dz_pkg::*;
(
   input  logic [DZ_ROWS-1:0] row,
   output dz_bus_class_t      cls,
   output dz_row_idx_t        idx
);

   logic [3:0] zeros;

   always_comb begin
      zeros = '0;
      idx   = '0;
      for (int i = 0; i < DZ_ROWS; i++) begin
         if (!row[i]) begin
            zeros = zeros + 4'd1;
            idx   = dz_row_idx_t'(i);
         end
      end
      if (zeros == 4'd0)      cls = IDLE;
      else if (zeros == 4'd1) cls = ACTIVE;
      else                    cls = MULTI;
   end

endmodule

// File: rtl/dz_scan_decoder.sv
// dz_scan_decoder: rebuilds the 8x8 red/green frame from the scan bus into a double buffer.
// Optional macro DZ_SCAN_ERR_EN enables sticky multi-row error detection and frame abort.
module dz_scan_decoder
   import dz_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int FCNT_W        = 16
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [DZ_ROWS-1:0]  row,
   input  logic [DZ_COLS-1:0]  colg,
   input  logic [DZ_COLS-1:0]  colr,
   input  dz_row_idx_t         rd_row,
   output logic [DZ_COLS-1:0]  rd_green,
   output logic [DZ_COLS-1:0]  rd_red,
   output logic                frame_done,
   output logic [FCNT_W-1:0]   frame_cnt,
   output logic                err_multi,
   input  logic                err_clr
);

   localparam logic [8:0] SETTLE_MAX = 9'(SETTLE_CYCLES);
   localparam dz_scan_state_t ARM_STATE = (SETTLE_CYCLES <= 1) ? S_CAPT : S_SETTLE;

   dz_bus_class_t  bus_cls;
   dz_row_idx_t    bus_idx;
   logic [23:0]    bus;
   logic [23:0]    cmp_q;
   dz_row_idx_t    cap_idx;
   logic [7:0]     cnt_q;
   dz_scan_state_t state, state_nx;
   logic           cmp_load, cnt_inc, cap_en;
   logic           multi_abort, mask_full, commit;
   logic [DZ_ROWS-1:0] seen_mask;

   logic [DZ_COLS-1:0] work_g [DZ_ROWS];
   logic [DZ_COLS-1:0] work_r [DZ_ROWS];
   logic [DZ_COLS-1:0] disp_g [DZ_ROWS];
   logic [DZ_COLS-1:0] disp_r [DZ_ROWS];

   dz_row_onehot_dec u_dec (
      .row (row),
      .cls (bus_cls),
      .idx (bus_idx)
   );

   assign bus = {row, colg, colr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cmp_q   <= '0;
         cap_idx <= '0;
         cnt_q   <= '0;
      end else begin
         state <= state_nx;
         if (cmp_load) begin
            cmp_q   <= bus;
            cap_idx <= bus_idx;
            cnt_q   <= 8'd1;
         end else if (cnt_inc) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

   // HOLD watches only the row field: column edits on an already captured row never re-arm capture.
   always_comb begin
      state_nx = state;
      cmp_load = 1'b0;
      cnt_inc  = 1'b0;
      cap_en   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus_cls == ACTIVE) begin
               cmp_load = 1'b1;
               state_nx = ARM_STATE;
            end
         end
         S_SETTLE: begin
            if (bus_cls != ACTIVE) begin
               state_nx = S_IDLE;
            end else if (bus != cmp_q) begin
               cmp_load = 1'b1;
               state_nx = ARM_STATE;
            end else begin
               cnt_inc = 1'b1;
               if ({1'b0, cnt_q} + 9'd1 >= SETTLE_MAX) state_nx = S_CAPT;
            end
         end
         S_CAPT: begin
            if (bus_cls == MULTI) begin
               state_nx = S_IDLE;
            end else begin
               cap_en   = 1'b1;
               state_nx = S_HOLD;
            end
         end
         S_HOLD: begin
            if (row != cmp_q[23:16]) begin
               if (bus_cls == ACTIVE) begin
                  cmp_load = 1'b1;
                  state_nx = ARM_STATE;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

`ifdef DZ_SCAN_ERR_EN
   assign multi_abort = (bus_cls == MULTI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              err_multi <= 1'b0;
      else if (multi_abort) err_multi <= 1'b1;
      else if (err_clr)     err_multi <= 1'b0;
   end
`else
   logic err_clr_unused;
   assign multi_abort    = 1'b0;
   assign err_multi      = 1'b0;
   assign err_clr_unused = err_clr;
`endif

   assign mask_full = (seen_mask == '1);
   assign commit    = mask_full && !multi_abort;

   // A full mask can only exist for the single cycle after the completing capture, so commit never races a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seen_mask  <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         rd_green   <= '0;
         rd_red     <= '0;
         for (int i = 0; i < DZ_ROWS; i++) begin
            work_g[i] <= '0;
            work_r[i] <= '0;
            disp_g[i] <= '0;
            disp_r[i] <= '0;
         end
      end else begin
         frame_done <= commit;
         rd_green   <= disp_g[rd_row];
         rd_red     <= disp_r[rd_row];
         if (commit) begin
            disp_g    <= work_g;
            disp_r    <= work_r;
            frame_cnt <= frame_cnt + FCNT_W'(1);
         end
         if (cap_en) begin
            work_g[cap_idx] <= cmp_q[15:8];
            work_r[cap_idx] <= cmp_q[7:0];
         end
         if (multi_abort || mask_full) seen_mask <= '0;
         else if (cap_en)              seen_mask <= seen_mask | (DZ_ROWS'(1) << cap_idx);
      end
   end

endmodule

// File: tb/tb_dz_scan_decoder.sv
// Scoreboard bench for dz_scan_decoder; expectations adapt to DZ_SCAN_ERR_EN.
module tb_dz_scan_decoder;

   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  row, colg, colr;
   logic [2:0]  rd_row;
   logic [7:0]  rd_green, rd_red;
   logic        frame_done;
   logic [15:0] frame_cnt;
   logic        err_multi;
   logic        err_clr;

   int total = 0;
   int bad   = 0;

   logic [15:0] frame_q [$];
   logic [18:0] rd_q [$];
   logic        rd_req = 1'b0;
   logic        rd_vld;
   logic [15:0] exp_cnt;

   always #5 clk = ~clk;

   dz_scan_decoder #(.SETTLE_CYCLES(SETTLE), .FCNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .row        (row),
      .colg       (colg),
      .colr       (colr),
      .rd_row     (rd_row),
      .rd_green   (rd_green),
      .rd_red     (rd_red),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .err_multi  (err_multi),
      .err_clr    (err_clr)
   );

   always @(posedge clk or posedge rst) begin
      if (rst) rd_vld <= 1'b0;
      else     rd_vld <= rd_req;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a frame pulse or a read result.
   always @(negedge clk) begin
      logic [18:0] e;
      if (!rst) begin
         if (frame_done) begin
            if (frame_q.size() == 0) checkOutput("spurious_frame_done", 32'(frame_done), 32'd0);
            else checkOutput("frame_cnt_at_done", 32'(frame_cnt), 32'(frame_q.pop_front()));
         end
         if (rd_vld) begin
            if (rd_q.size() == 0) begin
               checkOutput("spurious_read", 32'(rd_vld), 32'd0);
            end else begin
               e = rd_q.pop_front();
               checkOutput($sformatf("rd_green_row%0d", e[18:16]), 32'(rd_green), 32'(e[15:8]));
               checkOutput($sformatf("rd_red_row%0d", e[18:16]), 32'(rd_red), 32'(e[7:0]));
            end
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] rw, input logic [7:0] g, input logic [7:0] r, input int cycles);
      row  = rw;
      colg = g;
      colr = r;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic scanRow(input int idx, input logic [7:0] g, input logic [7:0] r);
      applyStimulus(8'(~(8'd1 << idx)), g, r, 10);
   endtask

   task automatic readRow(input int idx, input logic [7:0] eg, input logic [7:0] er);
      rd_q.push_back({3'(idx), eg, er});
      rd_row = 3'(idx);
      rd_req = 1'b1;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
   endtask

   task automatic pushFrame();
      exp_cnt = exp_cnt + 16'd1;
      frame_q.push_back(exp_cnt);
   endtask

   initial begin
      int order [8] = '{7, 3, 0, 1, 2, 4, 6, 5};
      rst = 1'b1; row = 8'hFF; colg = '0; colr = '0; rd_row = '0; err_clr = 1'b0; exp_cnt = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset_rd_green", 32'(rd_green), 32'd0);
      checkOutput("reset_rd_red", 32'(rd_red), 32'd0);
      checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
      checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      checkOutput("reset_err_multi", 32'(err_multi), 32'd0);

      // In-order scan with row-index data
      for (int i = 0; i < 8; i++) begin
         if (i == 7) pushFrame();
         scanRow(i, 8'(i), 8'(8'h80 >> i));
      end
      applyStimulus(8'hFF, 8'h00, 8'h00, 4);
      readRow(5, 8'h05, 8'h04);
      readRow(0, 8'h00, 8'h80);
      readRow(7, 8'h07, 8'h01);

      // Short glitch on row 0 must not capture; the frame then completes only on row 0
      applyStimulus(8'hFE, 8'h33, 8'h44, SETTLE - 1);
      applyStimulus(8'hFF, 8'h00, 8'h00, 4);
      for (int i = 1; i < 8; i++) scanRow(i, 8'(i), 8'(8'h80 >> i));
      pushFrame();
      scanRow(0, 8'h00, 8'h80);
      applyStimulus(8'hFF, 8'h00, 8'h00, 4);

      // Multi-row event after rows 0..6
      for (int i = 0; i < 7; i++) scanRow(i, 8'(8'hC0 | i), 8'h0C);
      applyStimulus(8'hFC, 8'hFF, 8'hFF, 5);
      applyStimulus(8'hFF, 8'h00, 8'h00, 1);
`ifdef DZ_SCAN_ERR_EN
      checkOutput("err_multi_set", 32'(err_multi), 32'd1);
      err_clr = 1'b1;
      applyStimulus(8'hFF, 8'h00, 8'h00, 1);
      err_clr = 1'b0;
      checkOutput("err_multi_cleared", 32'(err_multi), 32'd0);
      err_clr = 1'b1;
      applyStimulus(8'hFC, 8'h00, 8'h00, 1);
      err_clr = 1'b0;
      applyStimulus(8'hFF, 8'h00, 8'h00, 1);
      checkOutput("err_set_beats_clr", 32'(err_multi), 32'd1);
      err_clr = 1'b1;
      applyStimulus(8'hFF, 8'h00, 8'h00, 1);
      err_clr = 1'b0;
      checkOutput("err_multi_cleared2", 32'(err_multi), 32'd0);
`else
      checkOutput("err_multi_tied", 32'(err_multi), 32'd0);
      err_clr = 1'b1;
      applyStimulus(8'hFF, 8'h00, 8'h00, 1);
      err_clr = 1'b0;
      checkOutput("err_multi_tied_clr", 32'(err_multi), 32'd0);
      pushFrame();
      scanRow(7, 8'hC7, 8'h0C);
      applyStimulus(8'hFF, 8'h00, 8'h00, 4);
      readRow(3, 8'hC3, 8'h0C);
      readRow(7, 8'hC7, 8'h0C);
`endif

      // Out-of-order scan commits only after the last missing row (5)
      for (int k = 0; k < 8; k++) begin
         if (k == 7) pushFrame();
         scanRow(order[k], 8'(8'hA0 | order[k]), 8'(8'h5A ^ order[k]));
      end
      applyStimulus(8'hFF, 8'h00, 8'h00, 4);
      for (int i = 0; i < 8; i++) readRow(i, 8'(8'hA0 | i), 8'(8'h5A ^ i));

      // Reset mid-frame discards the partial frame and clears the display
      for (int i = 0; i < 4; i++) scanRow(i, 8'(8'h30 | i), 8'h03);
      row = 8'hFF;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_cnt = '0;
      checkOutput("post_reset_frame_cnt", 32'(frame_cnt), 32'd0);
      readRow(0, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) scanRow(i, 8'(8'h60 | i), 8'h06);
      readRow(2, 8'h00, 8'h00);
      for (int i = 4; i < 8; i++) begin
         if (i == 7) pushFrame();
         scanRow(i, 8'(8'h60 | i), 8'h06);
      end
      applyStimulus(8'hFF, 8'h00, 8'h00, 4);
      checkOutput("frame_cnt_after_reset_frame", 32'(frame_cnt), 32'd1);
      readRow(2, 8'h62, 8'h06);
      readRow(6, 8'h66, 8'h06);

      // Column change while holding row 2 must not be recaptured
      scanRow(0, 8'h90, 8'h09);
      scanRow(1, 8'h91, 8'h09);
      applyStimulus(8'hFB, 8'h11, 8'h22, SETTLE + 5);
      applyStimulus(8'hFB, 8'h55, 8'h22, 6);
      for (int i = 3; i < 8; i++) begin
         if (i == 7) pushFrame();
         scanRow(i, 8'(8'h90 | i), 8'h09);
      end
      applyStimulus(8'hFF, 8'h00, 8'h00, 4);
      readRow(2, 8'h11, 8'h22);
      readRow(0, 8'h90, 8'h09);

      applyStimulus(8'hFF, 8'h00, 8'h00, 5);
      checkOutput("frames_pending", 32'(frame_q.size()), 32'd0);
      checkOutput("reads_pending", 32'(rd_q.size()), 32'd0);
      checkOutput("final_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
